gram_scheduler: RTL

- Sequencer for the two-MAC Gram-matrix datapath: computes B = Aᵀ·A for an A of ROWS×COLS coefficients.
- Accepts coefficients over a valid/ready stream and drives the coefficient-register one-hot load enables.
- Schedules the NPAIR = COLS·(COLS+1)/2 unique B entries onto MAC0/MAC1 and issues result-bank writes.
- Streams the results out under valid/ready backpressure. Sits between the coefficient input port, the coefficient register bank, the two MACs and the result bank/output mux.

---
 rtl/gram_pkg.sv | 24 ++
 rtl/gram_pair_rom.sv | 29 ++
 rtl/gram_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/gram_pkg.sv
// Shared definitions for the Gram-matrix scheduler (B = A^T * A).
// Holds the controller state encoding, default geometry constants and the
// small index helpers used by the scheduler and its pair decoder.
package gram_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FLUSH, DRAIN} state_t;

  localparam int DEF_ROWS    = 3;
  localparam int DEF_COLS    = 4;
  localparam int DEF_MAC_LAT = 1;
  localparam int DEF_IW      = 4;
  localparam int DEF_PW      = 4;

  // Number of unique entries of a symmetric cols x cols matrix.
  function automatic int npair(input int cols);
    return cols * (cols + 1) / 2;
  endfunction

  // Column-major coefficient register index of A[r][c].
  function automatic int coef_idx(input int r, input int c, input int rows);
    return c * rows + r;
  endfunction

endpackage

// File: rtl/gram_pair_rom.sv
// Combinational decode of a pair index p into the (i, j) coordinates of the
// upper triangle of B, ordered by column j ascending and then row i = 0..j.
// Ports: p (pair index), i (row of B), j (column of B). Out-of-range p
// decodes to (0, 0); the scheduler never enables a MAC with such a p.
module gram_pair_rom
  import gram_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int PW   = DEF_PW
) (
  input  logic [PW-1:0] p,
  output logic [PW-1:0] i,
  output logic [PW-1:0] j
);

  always_comb begin
    // NOTE: defaults first so every path assigns i and j; no latch is inferred.
    i = '0;
    j = '0;
    for (int c = 0; c < COLS; c++) begin
      // Column c occupies pair indices npair(c) .. npair(c) + c.
      if (int'(p) >= npair(c) && int'(p) <= npair(c) + c) begin
        j = PW'(c);
        i = PW'(int'(p) - npair(c));
      end
    end
  end

endmodule

// File: rtl/gram_scheduler.sv
// Sequencer for the two-MAC Gram-matrix datapath.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   start              begin a job (sampled only while idle)
//   cf_valid/cf_ready  coefficient input stream
//   ld_sel             one-hot coefficient register load enable
//   mac_en, mac_clr    per-MAC operate / first-term enables
//   mac*_a/b_sel       operand register selects
//   res_we, res*_addr  result bank writes, one port per MAC
//   out_valid/ready    result stream handshake, out_sel = bank read index
//   busy, done         activity flag and one-cycle completion pulse
module gram_scheduler
  import gram_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int MAC_LAT = DEF_MAC_LAT,
  parameter int IW      = DEF_IW,
  parameter int PW      = DEF_PW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cf_valid,
  output logic                 cf_ready,
  output logic [ROWS*COLS-1:0] ld_sel,
  output logic [1:0]           mac_en,
  output logic [1:0]           mac_clr,
  output logic [IW-1:0]        mac0_a_sel,
  output logic [IW-1:0]        mac0_b_sel,
  output logic [IW-1:0]        mac1_a_sel,
  output logic [IW-1:0]        mac1_b_sel,
  output logic [1:0]           res_we,
  output logic [PW-1:0]        res0_addr,
  output logic [PW-1:0]        res1_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        out_sel,
  output logic                 busy,
  output logic                 done
);

  localparam int NC    = ROWS * COLS;
  localparam int NPAIR = npair(COLS);
  localparam int NSLOT = (NPAIR + 1) / 2;
  localparam int CW    = 8;

  state_t        state;
  logic [CW-1:0] cnt;     // load count, flush count or drain count
  logic [CW-1:0] k_cnt;   // term within a dot product
  logic [CW-1:0] s_cnt;   // pair slot, one pair per MAC
  logic [PW-1:0] p0, p1;
  logic [PW-1:0] i0, j0, i1, j1;
  logic          last_term;

  assign p0        = PW'({s_cnt, 1'b0});
  assign p1        = PW'({s_cnt, 1'b1});
  assign last_term = (k_cnt == CW'(ROWS - 1));

  gram_pair_rom #(.COLS(COLS), .PW(PW)) u_rom0 (.p(p0), .i(i0), .j(j0));
  gram_pair_rom #(.COLS(COLS), .PW(PW)) u_rom1 (.p(p1), .i(i1), .j(j1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      k_cnt <= '0;
      s_cnt <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          cnt   <= '0;
        end
        LOAD: if (cf_valid) begin
          if (cnt == CW'(NC - 1)) begin
            state <= COMPUTE;
            cnt   <= '0;
            k_cnt <= '0;
            s_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMPUTE: begin
          if (last_term) begin
            k_cnt <= '0;
            if (s_cnt == CW'(NSLOT - 1)) begin
              state <= FLUSH;
              s_cnt <= '0;
              cnt   <= '0;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end
        FLUSH: begin
          // Wait out the MAC pipeline so the final writes land before draining.
          if (cnt == CW'(MAC_LAT - 1)) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: if (out_ready) begin
          if (cnt == CW'(NPAIR - 1)) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cf_ready   = (state == LOAD);
    ld_sel     = (state == LOAD && cf_valid) ? (NC'(1) << cnt) : '0;
    mac_en     = '0;
    mac_en[0]  = (state == COMPUTE) && (2 * int'(s_cnt) < NPAIR);
    mac_en[1]  = (state == COMPUTE) && (2 * int'(s_cnt) + 1 < NPAIR);
    mac_clr    = mac_en & {2{k_cnt == '0}};
    mac0_a_sel = mac_en[0] ? IW'(coef_idx(int'(k_cnt), int'(i0), ROWS)) : '0;
    mac0_b_sel = mac_en[0] ? IW'(coef_idx(int'(k_cnt), int'(j0), ROWS)) : '0;
    mac1_a_sel = mac_en[1] ? IW'(coef_idx(int'(k_cnt), int'(i1), ROWS)) : '0;
    mac1_b_sel = mac_en[1] ? IW'(coef_idx(int'(k_cnt), int'(j1), ROWS)) : '0;
    out_valid  = (state == DRAIN);
    out_sel    = out_valid ? PW'(cnt) : '0;
    busy       = (state != IDLE);
  end

  // Write delay line: {en, p} issued on each final-term cycle, MAC_LAT deep.
  logic [1:0]    we_pipe [MAC_LAT];
  logic [PW-1:0] a0_pipe [MAC_LAT];
  logic [PW-1:0] a1_pipe [MAC_LAT];

  always_ff @(posedge clk) begin
    // NOTE: this small array is reset because its enable bits drive res_we
    // directly; a wide data memory would normally be left unreset.
    if (rst) begin
      for (int n = 0; n < MAC_LAT; n++) begin
        we_pipe[n] <= '0;
        a0_pipe[n] <= '0;
        a1_pipe[n] <= '0;
      end
    end else begin
      we_pipe[0] <= mac_en & {2{last_term}};
      a0_pipe[0] <= (mac_en[0] && last_term) ? p0 : '0;
      a1_pipe[0] <= (mac_en[1] && last_term) ? p1 : '0;
      for (int n = 1; n < MAC_LAT; n++) begin
        we_pipe[n] <= we_pipe[n-1];
        a0_pipe[n] <= a0_pipe[n-1];
        a1_pipe[n] <= a1_pipe[n-1];
      end
    end
  end

  assign res_we    = we_pipe[MAC_LAT-1];
  assign res0_addr = a0_pipe[MAC_LAT-1];
  assign res1_addr = a1_pipe[MAC_LAT-1];

endmodule
